// File: rtl/traffic_controller_param_if.sv
// Signal bundle between a traffic-light controller and its environment:
// demand and pre-emption inputs, light and status outputs.
interface traffic_controller_param_if #(
  parameter int N_DIR = 4,
  parameter int DIR_W = 2
);
  logic                 en;
  logic [N_DIR-1:0]     veh_req;
  logic                 force_req;
  logic [DIR_W-1:0]     force_dir;
  logic [3*N_DIR-1:0]   light;
  logic [DIR_W-1:0]     dir_o;
  logic [1:0]           state_o;
  logic                 phase_start;

  modport master (
    output en, veh_req, force_req, force_dir,
    input  light, dir_o, state_o, phase_start
  );

  modport slave (
    input  en, veh_req, force_req, force_dir,
    output light, dir_o, state_o, phase_start
  );
endinterface

// File: rtl/traffic_controller_param.sv
// N-approach round-robin traffic-light controller with demand skipping,
// emergency pre-emption and flashing-yellow fallback. Lights decode from registers only.
module traffic_controller_param #(
  parameter int N_DIR      = 4,
  parameter int DIR_W      = 2,
  parameter int GREEN_CYC  = 10,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int FLASH_CYC  = 4,
  parameter int CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        res_n,
  traffic_controller_param_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10,
    ST_FLASH  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYC - 1);
  localparam logic [DIR_W-1:0] DIR_LAST    = DIR_W'(N_DIR - 1);
  localparam logic [DIR_W:0]   N_DIR_V     = (DIR_W + 1)'(N_DIR);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIR_W-1:0]   dir_q, dir_d, next_dir;
  logic               flash_ph_q, flash_ph_d;
  logic               ps_q, ps_d;
  logic               force_valid;
  logic [3*N_DIR-1:0] light;

  // Out-of-range pre-emption targets are treated as no request at all.
  assign force_valid = bus.force_req && ({1'b0, bus.force_dir} < N_DIR_V);

  // Scan runs from farthest to nearest so the nearest demanding approach wins;
  // the current approach (k = N_DIR) is the last resort.
  always_comb begin
    next_dir = (dir_q == DIR_LAST) ? '0 : dir_q + 1'b1;
    if (force_valid) begin
      next_dir = bus.force_dir;
    end else begin
      for (int k = N_DIR; k >= 1; k--) begin
        if (bus.veh_req[DIR_W'((int'(dir_q) + k) % N_DIR)])
          next_dir = DIR_W'((int'(dir_q) + k) % N_DIR);
      end
    end
  end

  // NOTE: every next-state variable is defaulted first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    flash_ph_d = flash_ph_q;
    ps_d       = 1'b0;
    if (!bus.en) begin
      if (state_q != ST_FLASH) begin
        state_d    = ST_FLASH;
        cnt_d      = '0;
        flash_ph_d = 1'b1;
      end else if (cnt_q == FLASH_LAST) begin
        cnt_d      = '0;
        flash_ph_d = ~flash_ph_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      case (state_q)
        ST_FLASH: begin
          state_d = ST_ALLRED;
          cnt_d   = '0;
        end
        ST_ALLRED: begin
          if (cnt_q == ALLRED_LAST) begin
            state_d = ST_GREEN;
            cnt_d   = '0;
            dir_d   = next_dir;
            ps_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GREEN: begin
          // Pre-emption to another approach truncates green; to this one, freezes it.
          if (force_valid && bus.force_dir != dir_q) begin
            state_d = ST_YELLOW;
            cnt_d   = '0;
          end else if (!force_valid) begin
            if (cnt_q == GREEN_LAST) begin
              state_d = ST_YELLOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_YELLOW: begin
          if (cnt_q == YELLOW_LAST) begin
            state_d = ST_ALLRED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= ST_ALLRED;
      cnt_q      <= '0;
      dir_q      <= DIR_LAST;
      flash_ph_q <= 1'b0;
      ps_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      flash_ph_q <= flash_ph_d;
      ps_q       <= ps_d;
    end
  end

  always_comb begin
    light = '0;
    for (int d = 0; d < N_DIR; d++) begin
      light[3*d +: 3] = 3'b100;
      case (state_q)
        ST_GREEN:  if (DIR_W'(d) == dir_q) light[3*d +: 3] = 3'b001;
        ST_YELLOW: if (DIR_W'(d) == dir_q) light[3*d +: 3] = 3'b010;
        ST_FLASH:  light[3*d +: 3] = flash_ph_q ? 3'b010 : 3'b000;
        default: ;
      endcase
    end
  end

  assign bus.light       = light;
  assign bus.dir_o       = dir_q;
  assign bus.state_o     = state_q;
  assign bus.phase_start = ps_q;

endmodule

// File: tb/tb_traffic_controller_param.sv
// Scoreboard bench for traffic_controller_param: a countdown-style reference model
// queues the expected registered outputs for every clock, compared one cycle later.
module tb_traffic_controller_param;

  localparam int N  = 4;
  localparam int DW = 3;
  localparam int G  = 10;
  localparam int Y  = 3;
  localparam int A  = 2;
  localparam int F  = 4;
  localparam logic [3*N-1:0] ALL_RED = 12'h924;

  typedef enum logic [1:0] {M_ALLRED = 2'b00, M_GREEN = 2'b01,
                            M_YELLOW = 2'b10, M_FLASH = 2'b11} mstate_e;

  typedef struct packed {
    logic [3*N-1:0] light;
    logic [DW-1:0]  dir;
    logic [1:0]     state;
    logic           ps;
  } exp_t;

  logic clk = 1'b0;
  logic res_n;
  always #5 clk = ~clk;

  traffic_controller_param_if #(.N_DIR(N), .DIR_W(DW)) bus ();

  traffic_controller_param #(
    .N_DIR(N), .DIR_W(DW), .GREEN_CYC(G), .YELLOW_CYC(Y),
    .ALLRED_CYC(A), .FLASH_CYC(F), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];

  mstate_e m_state;
  int      m_left;
  int      m_dir;
  logic    m_ph;
  logic    m_ps;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_ALLRED;
    m_left  = A - 1;
    m_dir   = N - 1;
    m_ph    = 1'b0;
    m_ps    = 1'b0;
  endtask

  function automatic bit force_ok();
    return bus.force_req && (int'(bus.force_dir) < N);
  endfunction

  function automatic int pick_dir();
    if (force_ok()) return int'(bus.force_dir);
    for (int k = 1; k <= N; k++)
      if (bus.veh_req[(m_dir + k) % N]) return (m_dir + k) % N;
    return (m_dir + 1) % N;
  endfunction

  // m_left = cycles remaining in the phase after the current one.
  task automatic model_step();
    bit fv;
    fv   = force_ok();
    m_ps = 1'b0;
    if (!bus.en) begin
      if (m_state != M_FLASH) begin
        m_state = M_FLASH; m_left = F - 1; m_ph = 1'b1;
      end else if (m_left == 0) begin
        m_left = F - 1; m_ph = ~m_ph;
      end else m_left--;
    end else begin
      case (m_state)
        M_FLASH: begin m_state = M_ALLRED; m_left = A - 1; end
        M_ALLRED:
          if (m_left == 0) begin
            m_dir = pick_dir(); m_state = M_GREEN; m_left = G - 1; m_ps = 1'b1;
          end else m_left--;
        M_GREEN:
          if (fv && int'(bus.force_dir) != m_dir) begin
            m_state = M_YELLOW; m_left = Y - 1;
          end else if (!fv) begin
            if (m_left == 0) begin m_state = M_YELLOW; m_left = Y - 1; end
            else m_left--;
          end
        default:
          if (m_left == 0) begin m_state = M_ALLRED; m_left = A - 1; end
          else m_left--;
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int d = 0; d < N; d++) begin
      case (m_state)
        M_ALLRED: e.light[3*d +: 3] = 3'b100;
        M_GREEN:  e.light[3*d +: 3] = (d == m_dir) ? 3'b001 : 3'b100;
        M_YELLOW: e.light[3*d +: 3] = (d == m_dir) ? 3'b010 : 3'b100;
        default:  e.light[3*d +: 3] = m_ph ? 3'b010 : 3'b000;
      endcase
    end
    e.dir   = DW'(m_dir);
    e.state = m_state;
    e.ps    = m_ps;
    return e;
  endfunction

  task automatic cycle();
    exp_t e;
    model_step();
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("light",       32'(bus.light),       32'(e.light));
    check("dir_o",       32'(bus.dir_o),       32'(e.dir));
    check("state_o",     32'(bus.state_o),     32'(e.state));
    check("phase_start", 32'(bus.phase_start), 32'(e.ps));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic run_until(input mstate_e st, input int left, input int dir, input string tag);
    for (int i = 0; i < 200; i++) begin
      if (m_state == st && m_left == left && m_dir == dir) break;
      cycle();
    end
    check({tag, "_reached"}, 32'(m_state == st && m_left == left && m_dir == dir), 32'd1);
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    model_reset();
    sb_q.delete();
    @(posedge clk);
    #1;
    check("rst_light", 32'(bus.light),       32'(ALL_RED));
    check("rst_dir",   32'(bus.dir_o),       32'(N - 1));
    check("rst_state", 32'(bus.state_o),     32'd0);
    check("rst_ps",    32'(bus.phase_start), 32'd0);
    res_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.en        = 1'b1;
    bus.veh_req   = '0;
    bus.force_req = 1'b0;
    bus.force_dir = '0;
    res_n         = 1'b0;
    #2;

    // Round robin with no demand, covering a full wrap back to approach 0.
    do_reset();
    run(80);

    // Sole demand on approach 3: it is re-served every time.
    do_reset();
    bus.veh_req = 4'b1000;
    run(45);
    bus.veh_req = '0;

    // Pre-emption truncating approach 0 at cnt=4, then freezing approach 2's green.
    do_reset();
    run_until(M_GREEN, G - 1 - 4, 0, "green0_cnt4");
    bus.force_req = 1'b1;
    bus.force_dir = 3'd2;
    run_until(M_GREEN, G - 1, 2, "force_green2");
    run(20);
    bus.force_req = 1'b0;
    run(18);

    // Flashing-yellow mode entered mid-green, then recovery through all-red.
    do_reset();
    run_until(M_GREEN, 5, 0, "mid_green");
    bus.en = 1'b0;
    run(20);
    bus.en = 1'b1;
    run(20);

    // Asynchronous reset between clock edges while yellow.
    do_reset();
    run_until(M_YELLOW, Y - 2, 0, "mid_yellow");
    #3;
    res_n = 1'b0;
    #1;
    check("async_light", 32'(bus.light),   32'(ALL_RED));
    check("async_state", 32'(bus.state_o), 32'd0);
    check("async_dir",   32'(bus.dir_o),   32'(N - 1));
    do_reset();
    run(20);

    // Out-of-range pre-emption target is ignored.
    do_reset();
    bus.force_req = 1'b1;
    bus.force_dir = 3'd5;
    run(40);
    bus.force_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_controller_param.md
Name: traffic_controller_param

Overview:
Parametrised N-approach traffic-light controller for the traffic FSM family. It is the next generation of the fixed 4-bit-output controller. It sequences green, yellow and all-red phases round-robin across N_DIR approaches and skips approaches with no vehicle demand. It also supports emergency pre-emption to a chosen approach and a flashing-yellow mode when disabled. All outputs are Moore and registered, with no combinational path from inputs to lights.

Parameters:
N_DIR, 4, number of approaches (2..16)
DIR_W, 2, width of direction index; must satisfy 2**DIR_W >= N_DIR
GREEN_CYC, 10, green duration in clk cycles (>=1)
YELLOW_CYC, 3, yellow duration in cycles (>=1)
ALLRED_CYC, 2, all-red clearance duration in cycles (>=1)
FLASH_CYC, 4, half-period of flashing yellow in cycles (>=1)
CNT_W, 8, phase counter width; must hold max(durations)-1

Ports:
clk  in  1  clock, rising edge
res_n  in  1  asynchronous active-low reset
en  in  1  1 = normal sequencing, 0 = flashing-yellow mode
veh_req  in  N_DIR  per-approach vehicle demand, level-sensitive
force_req  in  1  emergency pre-emption request, level
force_dir  in  DIR_W  approach to pre-empt to
light  out  3*N_DIR  per approach d: bits [3d+2:3d] = {red,yellow,green}
dir_o  out  DIR_W  current/last served approach
state_o  out  2  00 ALLRED, 01 GREEN, 10 YELLOW, 11 FLASH
phase_start  out  1  one-cycle pulse on the first cycle of each GREEN

Behaviour:
- Reset (res_n=0, asynchronous, effective immediately, also mid-operation):
  - state=ALLRED, cnt=0, dir_o=N_DIR-1.
  - light: every approach 100 (red).
  - phase_start=0.
- cnt counts cycles spent in the current state. A state exits on the edge where cnt==DUR-1. cnt clears to 0 on every state change.
- Light decode from the state registers:
  - ALLRED: all approaches 100.
  - GREEN: approach dir_o = 001, others 100.
  - YELLOW: approach dir_o = 010, others 100.
  - FLASH: all approaches 010 when flash_ph=1, 000 when flash_ph=0.
- ALLRED (ALLRED_CYC cycles) -> GREEN. dir_o is loaded with next_dir and phase_start=1 for that first GREEN cycle.
- next_dir priority, evaluated on the exit edge:
  - (1) force_dir, if force_req=1 and force_dir<N_DIR.
  - (2) otherwise the first d in order dir_o+1, dir_o+2, ..., dir_o+N_DIR (mod N_DIR) with veh_req[d]=1; the current approach is checked last, so it may be re-served.
  - (3) if veh_req is all zero, (dir_o+1) mod N_DIR.
  - Consequence: dir_o reset value N_DIR-1 makes the first green approach 0 when there is no demand.
- GREEN (GREEN_CYC cycles) -> YELLOW, with these overrides:
  - Valid force_req with force_dir != dir_o: exit to YELLOW on the next edge regardless of cnt (truncation).
  - Valid force_req with force_dir == dir_o: cnt is frozen and GREEN is held while force_req=1. Normal countdown resumes from the frozen value after release.
- YELLOW (YELLOW_CYC cycles) -> ALLRED. Yellow and all-red are never truncated by force_req; pre-emption takes effect at the ALLRED exit.
- A force_req with force_dir >= N_DIR is ignored entirely.
- en handling:
  - en=0 in any non-FLASH state: next edge enters FLASH with flash_ph=1, cnt=0.
  - In FLASH, flash_ph toggles every FLASH_CYC cycles.
  - en returning to 1: next edge enters ALLRED with cnt=0; dir_o is retained. A full clearance always follows flash.
  - en has priority over force_req and the timers.
- Multiple events on one edge, highest priority first: reset, en=0, force truncation, timer expiry.
- Arithmetic: index math is mod N_DIR with no out-of-range dir_o; cnt never exceeds DUR-1.

Test Plan:
- Reset then release, veh_req=0, en=1: 2 cycles all-red; approach 0 green for 10 cycles with phase_start pulse; yellow 3; all-red 2; approach 1 green. After approach 3, wraps to 0.
- veh_req=4'b1000 constant from reset: every green is approach 3 (re-served), with yellow/all-red between greens. Approaches 0-2 stay red throughout.
- Approach 0 green at cnt=4, force_req=1 with force_dir=2: next cycle approach 0 yellow for 3, all-red 2, then approach 2 green. Hold force_req for 20 cycles: approach 2 stays green for all 20. Drop force_req: green ends after the remaining 10-1 cycles.
- en=0 mid-green: next cycle all approaches 010 for 4 cycles, then 000 for 4 cycles, repeating. en=1: all-red for 2 cycles, then green on next_dir computed from the retained dir_o.
- Assert res_n=0 asynchronously mid-yellow, between clock edges: light goes all-red and state_o=00 immediately, without waiting for a clock edge. Sequence restarts with approach 0 after release.
- force_dir=5 with N_DIR=4: ignored; the normal round-robin sequence is unchanged.
